// File: rtl/conv2_window_buf.sv
// conv2 window producer: per-channel line buffers feeding 5x5x3 windows.
// Ports: clk/rst, valid_in + data_in1..3 in; win1..3, valid_out_buf, frame_done out.
module conv2_window_buf #(
  parameter int WIDTH = 12,
  parameter int K     = 5,
  parameter int DW    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DW-1:0]     data_in1,
  input  logic [DW-1:0]     data_in2,
  input  logic [DW-1:0]     data_in3,
  output logic [K*K*DW-1:0] win1,
  output logic [K*K*DW-1:0] win2,
  output logic [K*K*DW-1:0] win3,
  output logic              valid_out_buf,
  output logic              frame_done
);

  localparam int L  = WIDTH*(K-1)+K;
  localparam int SW = L*DW;
  localparam int NW = K*K*DW;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  localparam logic [CW-1:0] EDGE = CW'(K-1);

  logic [SW-1:0] sr1_q, sr1_d;
  logic [SW-1:0] sr2_q, sr2_d;
  logic [SW-1:0] sr3_q, sr3_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [NW-1:0] win1_q, win1_d;
  logic [NW-1:0] win2_q, win2_d;
  logic [NW-1:0] win3_q, win3_d;
  logic          vob_q, vob_d;
  logic          fd_q, fd_d;
  logic          win_hit;
  logic          last_hit;

  // Stage s lives at bits [s*DW +: DW]; stage 0 is the newest pixel.
  function automatic logic [NW-1:0] tap(input logic [SW-1:0] sr);
    logic [NW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w[(r*K+c)*DW +: DW] = sr[((K-1-r)*WIDTH + (K-1-c))*DW +: DW];
      end
    end
    return w;
  endfunction

  // Shifted image including the pixel being accepted this cycle.
  always_comb begin
    sr1_d = {sr1_q[SW-DW-1:0], data_in1};
    sr2_d = {sr2_q[SW-DW-1:0], data_in2};
    sr3_d = {sr3_q[SW-DW-1:0], data_in3};
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Windows straddling a row wrap (col < K-1) are never flagged.
  assign win_hit  = valid_in && (row_q >= EDGE) && (col_q >= EDGE);
  assign last_hit = valid_in && (row_q == LAST) && (col_q == LAST);

  always_comb begin
    vob_d  = win_hit;
    fd_d   = last_hit;
    win1_d = win_hit ? tap(sr1_d) : win1_q;
    win2_d = win_hit ? tap(sr2_d) : win2_q;
    win3_d = win_hit ? tap(sr3_d) : win3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr1_q  <= '0;
      sr2_q  <= '0;
      sr3_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
      win1_q <= '0;
      win2_q <= '0;
      win3_q <= '0;
      vob_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      if (valid_in) begin
        sr1_q <= sr1_d;
        sr2_q <= sr2_d;
        sr3_q <= sr3_d;
      end
      col_q  <= col_d;
      row_q  <= row_d;
      win1_q <= win1_d;
      win2_q <= win2_d;
      win3_q <= win3_d;
      vob_q  <= vob_d;
      fd_q   <= fd_d;
    end
  end

  assign win1          = win1_q;
  assign win2          = win2_q;
  assign win3          = win3_q;
  assign valid_out_buf = vob_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_conv2_window_buf.sv
// Bench for conv2_window_buf: directed frames with an image-model scoreboard.
// Expected windows are cut from a 2-D image model and checked at exact latency.
module tb_conv2_window_buf;

  localparam int WIDTH = 12;
  localparam int K     = 5;
  localparam int DW    = 12;
  localparam int N     = K*K*DW;

  typedef struct {
    logic [N-1:0] w1;
    logic [N-1:0] w2;
    logic [N-1:0] w3;
    logic         fd;
    int           due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in1, data_in2, data_in3;
  logic [N-1:0]  win1, win2, win3;
  logic          valid_out_buf;
  logic          frame_done;

  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;
  int npulse  = 0;
  int nfd     = 0;
  bit cap     = 1'b0;

  logic [N-1:0] fw1, fw2, fw3, lw1;
  logic [DW-1:0] img1 [WIDTH][WIDTH];
  logic [DW-1:0] img2 [WIDTH][WIDTH];
  logic [DW-1:0] img3 [WIDTH][WIDTH];
  int brow = 0;
  int bcol = 0;
  exp_t q[$];

  conv2_window_buf #(.WIDTH(WIDTH), .K(K), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .data_in1      (data_in1),
    .data_in2      (data_in2),
    .data_in3      (data_in3),
    .win1          (win1),
    .win2          (win2),
    .win3          (win3),
    .valid_out_buf (valid_out_buf),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] el(input logic [N-1:0] v, input int e);
    return v[e*DW +: DW];
  endfunction

  task automatic accept(input int v);
    exp_t e;
    data_in1 = DW'(v);
    data_in2 = DW'(-v);
    data_in3 = 12'h7FF;
    valid_in = 1'b1;
    img1[brow][bcol] = data_in1;
    img2[brow][bcol] = data_in2;
    img3[brow][bcol] = data_in3;
    if (brow >= K-1 && bcol >= K-1) begin
      e.w1 = '0; e.w2 = '0; e.w3 = '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          e.w1[(r*K+c)*DW +: DW] = img1[brow-K+1+r][bcol-K+1+c];
          e.w2[(r*K+c)*DW +: DW] = img2[brow-K+1+r][bcol-K+1+c];
          e.w3[(r*K+c)*DW +: DW] = img3[brow-K+1+r][bcol-K+1+c];
        end
      end
      e.fd  = (brow == WIDTH-1) && (bcol == WIDTH-1);
      e.due = cyc + 1;
      q.push_back(e);
    end
    if (bcol == WIDTH-1) begin
      bcol = 0;
      brow = (brow == WIDTH-1) ? 0 : brow + 1;
    end else begin
      bcol++;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input int off, input bit stall);
    for (int i = 0; i < WIDTH*WIDTH; i++) begin
      accept(off + (i / WIDTH)*WIDTH + (i % WIDTH));
      if (i == 0) cap = 1'b1;
      if (stall) idle(1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("pulse_valid", N'(valid_out_buf), N'(1'b1));
      chk("pulse_win1", win1, e.w1);
      chk("pulse_win2", win2, e.w2);
      chk("pulse_win3", win3, e.w3);
      chk("pulse_frame_done", N'(frame_done), N'(e.fd));
    end else begin
      chk("idle_valid", N'(valid_out_buf), '0);
      chk("idle_frame_done", N'(frame_done), '0);
    end
    if (valid_out_buf) begin
      npulse++;
      lw1 = win1;
      if (cap) begin
        fw1 = win1; fw2 = win2; fw3 = win3;
        cap = 1'b0;
      end
    end
    if (frame_done) nfd++;
  end

  initial begin
    logic [N-1:0] all7ff;
    int p0, f0;
    for (int e = 0; e < K*K; e++) all7ff[e*DW +: DW] = 12'h7FF;
    rst = 1'b1;
    valid_in = 1'b0;
    data_in1 = '0; data_in2 = '0; data_in3 = '0;
    idle(3);
    chk("rst_valid", N'(valid_out_buf), '0);
    chk("rst_frame_done", N'(frame_done), '0);
    chk("rst_win1", win1, '0);
    chk("rst_win2", win2, '0);
    chk("rst_win3", win3, '0);
    rst = 1'b0;
    idle(2);

    // Continuous ramp frame, all three channels.
    frame(0, 1'b0);
    idle(3);
    chk("ramp_pulses", N'(npulse), N'(64));
    chk("ramp_frame_done", N'(nfd), N'(1));
    chk("ramp_e0", N'(el(fw1, 0)), N'(0));
    chk("ramp_e4", N'(el(fw1, 4)), N'(4));
    chk("ramp_e20", N'(el(fw1, 20)), N'(48));
    chk("ramp_e24", N'(el(fw1, 24)), N'(52));
    chk("ch2_e24", N'(el(fw2, 24)), N'(12'hFCC));
    chk("ch3_all", fw3, all7ff);
    chk("last_e24", N'(el(lw1, 24)), N'(143));

    // Same ramp with valid_in low every other cycle.
    p0 = npulse; f0 = nfd;
    frame(0, 1'b1);
    idle(3);
    chk("stall_pulses", N'(npulse - p0), N'(64));
    chk("stall_frame_done", N'(nfd - f0), N'(1));
    chk("stall_e24", N'(el(fw1, 24)), N'(52));

    // Back-to-back frames, second offset by 1000.
    p0 = npulse; f0 = nfd;
    frame(0, 1'b0);
    frame(1000, 1'b0);
    idle(3);
    chk("b2b_pulses", N'(npulse - p0), N'(128));
    chk("b2b_frame_done", N'(nfd - f0), N'(2));
    chk("b2b_e0", N'(el(fw1, 0)), N'(1000));
    chk("b2b_e24", N'(el(fw1, 24)), N'(1052));

    // Reset after 70 accepts, then a fresh frame.
    for (int i = 0; i < 70; i++) accept((i / WIDTH)*WIDTH + (i % WIDTH));
    rst = 1'b1;
    q.delete();
    brow = 0; bcol = 0;
    #1;
    chk("mid_rst_valid", N'(valid_out_buf), '0);
    chk("mid_rst_frame_done", N'(frame_done), '0);
    chk("mid_rst_win1", win1, '0);
    chk("mid_rst_win2", win2, '0);
    chk("mid_rst_win3", win3, '0);
    idle(2);
    rst = 1'b0;
    idle(1);
    p0 = npulse; f0 = nfd;
    frame(1500, 1'b0);
    idle(3);
    chk("post_rst_pulses", N'(npulse - p0), N'(64));
    chk("post_rst_frame_done", N'(nfd - f0), N'(1));
    chk("post_rst_e0", N'(el(fw1, 0)), N'(1500));
    chk("post_rst_e24", N'(el(fw1, 24)), N'(1552));
    chk("sb_drained", N'(q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
